// File: rtl/matrix_pkg.sv
// Shared fixed-point types, FSM state encoding and identity-matrix helper for xform_sequencer.
package matrix_pkg;

  localparam int FXP_WI = 8;
  localparam int FXP_WF = 8;
  localparam int FXP_W  = FXP_WI + FXP_WF;

  typedef logic [FXP_W-1:0] fxp_t;
  typedef fxp_t [3:0]       vec4_t;
  // Row-major: element r*4+c is row r, column c.
  typedef fxp_t [15:0]      mat4_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    DONE = 2'd2
  } xform_state_t;

  function automatic mat4_t mat_identity();
    mat4_t m;
    m = '0;
    for (int i = 0; i < 4; i++) m[i*5] = fxp_t'(1) << FXP_WF;
    return m;
  endfunction

endpackage

// File: rtl/dot_product.sv
// Signed fixed-point 4-element dot product with round-half-up and wrapping output.
module dot_product #(
  parameter int WII = 8,
  parameter int WIF = 8,
  parameter int WOI = 8,
  parameter int WOF = 8
) (
  input  logic [3:0][WII+WIF-1:0] a,
  input  logic [3:0][WII+WIF-1:0] b,
  output logic [WOI+WOF-1:0]      y
);

  localparam int WIN = WII + WIF;
  localparam int WP  = 2 * WIN;
  localparam int WS  = WP + 2;
  // Products carry 2*WIF fraction bits; drop down to WOF with a half-LSB bias.
  localparam int SH  = 2 * WIF - WOF;
  localparam logic [WS-1:0] HALF = WS'(1) << (SH - 1);

  logic signed [WP-1:0] prod [4];
  logic signed [WS-1:0] acc;
  logic signed [WS-1:0] rnd;

  always_comb begin
    acc = '0;
    for (int i = 0; i < 4; i++) begin
      prod[i] = $signed(a[i]) * $signed(b[i]);
      acc     = acc + WS'(prod[i]);
    end
    rnd = acc + $signed(HALF);
    y   = (WOI+WOF)'(rnd >>> SH);
  end

endmodule

// File: rtl/xform_sequencer.sv
// Applies a 4x4 fixed-point matrix to vertices one row per clock through a shared dot_product.
// Optional matrix double-buffering is enabled with `define XFORM_MAT_DBUF_EN.
module xform_sequencer
  import matrix_pkg::*;
#(
  parameter int WI = FXP_WI,
  parameter int WF = FXP_WF
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         mat_valid,
  input  mat4_t        mat_in,
  output logic         mat_ready,
  input  logic         in_valid,
  input  vec4_t        in_vtx,
  output logic         in_ready,
  output logic         out_valid,
  output vec4_t        out_vtx,
  input  logic         out_ready,
  output logic         busy,
  output xform_state_t dbg_state
);

  if (WI != FXP_WI || WF != FXP_WF) begin : g_width_check
    $error("xform_sequencer WI/WF must match matrix_pkg FXP_WI/FXP_WF");
  end

  localparam logic [1:0] S_IDLE = IDLE;
  localparam logic [1:0] S_ROW  = ROW;
  localparam logic [1:0] S_DONE = DONE;

  // Every port pair transfers on a rising edge where valid && ready are both high.
  logic [1:0] state;
  logic [1:0] cnt;
  vec4_t      vtx_q;
  vec4_t      row_sel;
  mat4_t      mat_act;
  fxp_t       dp_y;
  logic       in_fire;
  logic       mat_fire;
  logic       out_fire;
  logic       mat_block;

  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);
  assign dbg_state = xform_state_t'(state);
  assign out_fire  = out_valid && out_ready;

`ifdef XFORM_MAT_DBUF_EN
  mat4_t mat_shadow;
  logic  pending;

  assign mat_ready = !pending;
  assign mat_block = pending || mat_valid;

  // The swap waits until no row is being computed so a vertex never mixes matrices.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      mat_act    <= mat_identity();
      mat_shadow <= mat_identity();
      pending    <= 1'b0;
    end else if (mat_fire) begin
      mat_shadow <= mat_in;
      pending    <= 1'b1;
    end else if (pending && state != S_ROW) begin
      mat_act <= mat_shadow;
      pending <= 1'b0;
    end
  end
`else
  assign mat_ready = (state == S_IDLE);
  assign mat_block = mat_valid;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) mat_act <= mat_identity();
    else if (mat_fire) mat_act <= mat_in;
  end
`endif

  // Matrix traffic wins over vertices so a new vertex always sees the newest matrix.
  assign in_ready = (state == S_IDLE || out_fire) && !mat_block;
  assign in_fire  = in_valid && in_ready;
  assign mat_fire = mat_valid && mat_ready;

  always_comb begin
    case (cnt)
      2'd0:    row_sel = mat_act[3:0];
      2'd1:    row_sel = mat_act[7:4];
      2'd2:    row_sel = mat_act[11:8];
      default: row_sel = mat_act[15:12];
    endcase
  end

  dot_product #(
    .WII(WI),
    .WIF(WF),
    .WOI(WI),
    .WOF(WF)
  ) u_dot (
    .a(row_sel),
    .b(vtx_q),
    .y(dp_y)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state   <= S_IDLE;
      cnt     <= 2'd0;
      vtx_q   <= '0;
      out_vtx <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_fire) begin
            vtx_q <= in_vtx;
            cnt   <= 2'd0;
            state <= S_ROW;
          end
        end
        S_ROW: begin
          out_vtx[cnt] <= dp_y;
          cnt          <= cnt + 2'd1;
          if (cnt == 2'd3) state <= S_DONE;
        end
        S_DONE: begin
          if (in_fire) begin
            vtx_q <= in_vtx;
            cnt   <= 2'd0;
            state <= S_ROW;
          end else if (out_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
